// File: rtl/ff_bank_multimode.sv
// Bank of WIDTH independent flip-flops with a shared D/T/JK/SR mode select,
// registered per-bit change/SR-conflict flags and a saturating activity counter.
module ff_bank_multimode #(
    parameter int unsigned     WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int unsigned     CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] chg,
    output logic [WIDTH-1:0] sr_err,
    output logic [CNT_W-1:0] chg_cnt,
    output logic             cnt_sat
);

    typedef enum logic [1:0] {
        MODE_D  = 2'b00,
        MODE_T  = 2'b01,
        MODE_JK = 2'b10,
        MODE_SR = 2'b11
    } ff_mode_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ff_mode_e         mode_sel;
    logic [WIDTH-1:0] nq;
    logic [WIDTH-1:0] sr_hit;
    logic [WIDTH-1:0] diff;
    logic             any_chg;
    logic [CNT_W-1:0] cnt_next;

    assign mode_sel = ff_mode_e'(mode);

    // Per-bit next state for the selected flop type; SR 11 holds and flags a conflict.
    always_comb begin
        nq     = q;
        sr_hit = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            unique case (mode_sel)
                MODE_D:  nq[i] = a_in[i];
                MODE_T:  nq[i] = q[i] ^ a_in[i];
                MODE_JK: begin
                    unique case ({a_in[i], b_in[i]})
                        2'b10:   nq[i] = 1'b1;
                        2'b01:   nq[i] = 1'b0;
                        2'b11:   nq[i] = ~q[i];
                        default: nq[i] = q[i];
                    endcase
                end
                MODE_SR: begin
                    unique case ({a_in[i], b_in[i]})
                        2'b10:   nq[i] = 1'b1;
                        2'b01:   nq[i] = 1'b0;
                        2'b11:   sr_hit[i] = 1'b1;
                        default: nq[i] = q[i];
                    endcase
                end
                default: nq[i] = q[i];
            endcase
        end
    end

    // Change detection gated by enable; reset suppresses counting.
    always_comb begin
        diff    = en ? (nq ^ q) : '0;
        any_chg = (|diff) & ~rst;
    end

    // Saturating counter next value; clear still admits a same-cycle change.
    always_comb begin
        cnt_next = chg_cnt;
        if (clr_cnt) begin
            cnt_next = CNT_W'(any_chg);
        end else if (chg_cnt != CNT_MAX) begin
            cnt_next = chg_cnt + CNT_W'(any_chg);
        end
    end

    // State, flag and counter registers; reset dominates.
    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= RST_VAL;
            chg     <= '0;
            sr_err  <= '0;
            chg_cnt <= '0;
            cnt_sat <= 1'b0;
        end else begin
            q       <= en ? nq : q;
            chg     <= diff;
            sr_err  <= en ? sr_hit : '0;
            chg_cnt <= cnt_next;
            cnt_sat <= (cnt_next == CNT_MAX);
        end
    end

    // Complement output tracks q directly.
    assign qn = ~q;

endmodule
